controlunit_pipe: RTL and testbench

Parametrised, registered successor to the lab RISC-V control unit. It decodes the RV32I ALU subset plus LUI and the GPIO CSRRW instructions. A valid/ready handshake accepts one instruction per cycle, and a scoreboard of in-flight destination registers stalls read-after-write hazards. It sits between instruction fetch and the register-file/ALU/GPIO datapath, and drives registered control one cycle after acceptance.

---
 rtl/controlunit_pipe.sv | 235 +++++++++++++++++++++++
 tb/tb_controlunit_pipe.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/controlunit_pipe.sv
// Registered RV32I ALU-subset / LUI / GPIO-CSRRW decoder with valid/ready intake and RAW scoreboard.
// Optional build macro: ILLEGAL_CNT_EN adds a saturating illegal-instruction counter output.
module controlunit_pipe #(
  parameter int          XLEN         = 32,
  parameter int          HAZARD_DEPTH = 2,
  parameter logic [11:0] GPIO_OUT_CSR = 12'hF02,
  parameter logic [11:0] GPIO_IN_CSR  = 12'hF00
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  output logic            instr_ready,
  output logic            ctrl_valid,
  output logic            alusrc,
  output logic            regwrite,
  output logic [1:0]      regsel,
  output logic [3:0]      op,
  output logic            gpio_we,
  output logic [4:0]      rd_out,
  output logic [4:0]      rs1_out,
  output logic [4:0]      rs2_out,
  output logic [XLEN-1:0] imm_out,
  output logic            illegal
`ifdef ILLEGAL_CNT_EN
  ,
  output logic [15:0]     illegal_cnt
`endif
);

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_SYS = 7'b1110011;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd_f, rs1_f, rs2_f;
  logic [11:0] csr;

  assign opcode = instr[6:0];
  assign rd_f   = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1_f  = instr[19:15];
  assign rs2_f  = instr[24:20];
  assign funct7 = instr[31:25];
  assign csr    = instr[31:20];

  // Returns {legal, op}; alt selects the funct7=0100000 variant (SUB/SRA)
  function automatic logic [4:0] alu_sel(input logic alt, input logic [2:0] f3);
    logic [4:0] r;
    case ({alt, f3})
      4'b0_000: r = {1'b1, OP_ADD};
      4'b1_000: r = {1'b1, OP_SUB};
      4'b0_001: r = {1'b1, OP_SLL};
      4'b0_010: r = {1'b1, OP_SLT};
      4'b0_011: r = {1'b1, OP_SLTU};
      4'b0_100: r = {1'b1, OP_XOR};
      4'b0_101: r = {1'b1, OP_SRL};
      4'b1_101: r = {1'b1, OP_SRA};
      4'b0_110: r = {1'b1, OP_OR};
      4'b0_111: r = {1'b1, OP_AND};
      default:  r = {1'b0, OP_ADD};
    endcase
    return r;
  endfunction

  logic            dec_alusrc, dec_regwrite, dec_gpio_we, dec_illegal;
  logic [1:0]      dec_regsel;
  logic [3:0]      dec_op;
  logic [XLEN-1:0] dec_imm;
  logic            use_rs1, use_rs2;
  logic            f7_ok, is_shift;
  logic [4:0]      sel;

  assign f7_ok    = (funct7 & 7'b1011111) == 7'b0;
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    dec_alusrc   = 1'b0;
    dec_regwrite = 1'b0;
    dec_gpio_we  = 1'b0;
    dec_illegal  = 1'b0;
    dec_regsel   = 2'b01;
    dec_op       = OP_ADD;
    dec_imm      = '0;
    use_rs1      = 1'b0;
    use_rs2      = 1'b0;
    sel          = 5'b0;
    case (opcode)
      OPC_R: begin
        sel          = alu_sel(funct7[5], funct3);
        dec_illegal  = ~(f7_ok & sel[4]);
        dec_op       = sel[3:0];
        dec_regwrite = 1'b1;
        use_rs1      = 1'b1;
        use_rs2      = 1'b1;
      end
      OPC_I: begin
        // funct7 only qualifies the shifts; elsewhere those bits are immediate
        sel          = alu_sel(is_shift & funct7[5], funct3);
        dec_illegal  = ~sel[4] | (is_shift & ~f7_ok);
        dec_op       = sel[3:0];
        dec_alusrc   = 1'b1;
        dec_regwrite = 1'b1;
        use_rs1      = 1'b1;
        dec_imm      = is_shift ? XLEN'(rs2_f) : XLEN'($signed(instr[31:20]));
      end
      OPC_LUI: begin
        dec_imm      = XLEN'($signed({instr[31:12], 12'b0}));
        dec_regsel   = 2'b10;
        dec_regwrite = 1'b1;
      end
      OPC_SYS: begin
        if (funct3 == 3'b001 && csr == GPIO_OUT_CSR) begin
          dec_gpio_we = 1'b1;
          use_rs1     = 1'b1;
        end else if (funct3 == 3'b001 && csr == GPIO_IN_CSR) begin
          dec_regwrite = 1'b1;
          dec_regsel   = 2'b00;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      default: dec_illegal = 1'b1;
    endcase
    if (dec_illegal) begin
      dec_alusrc   = 1'b0;
      dec_regwrite = 1'b0;
      dec_gpio_we  = 1'b0;
      dec_regsel   = 2'b01;
      dec_op       = OP_ADD;
      dec_imm      = '0;
      use_rs1      = 1'b0;
      use_rs2      = 1'b0;
    end
    if (rd_f == 5'd0) dec_regwrite = 1'b0;
  end

  logic                    accept;
  logic [HAZARD_DEPTH-1:0] hit;

  assign instr_ready = ~(|hit);
  assign accept      = instr_valid & instr_ready;

  // Each entry is one in-flight writeback; entries age by one slot per cycle
  genvar gi;
  generate
    for (gi = 0; gi < HAZARD_DEPTH; gi++) begin : g_sb
      logic       wr_reg;
      logic [4:0] rd_reg;
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            wr_reg <= 1'b0;
            rd_reg <= 5'd0;
          end else begin
            wr_reg <= accept & dec_regwrite;
            rd_reg <= rd_f;
          end
        end
      end else begin : g_tail
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            wr_reg <= 1'b0;
            rd_reg <= 5'd0;
          end else begin
            wr_reg <= g_sb[gi-1].wr_reg;
            rd_reg <= g_sb[gi-1].rd_reg;
          end
        end
      end
      assign hit[gi] = wr_reg &
                       ((use_rs1 && rs1_f != 5'd0 && rs1_f == rd_reg) ||
                        (use_rs2 && rs2_f != 5'd0 && rs2_f == rd_reg));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_valid <= 1'b0;
      alusrc     <= 1'b0;
      regwrite   <= 1'b0;
      regsel     <= 2'b00;
      op         <= 4'b0000;
      gpio_we    <= 1'b0;
      rd_out     <= 5'd0;
      rs1_out    <= 5'd0;
      rs2_out    <= 5'd0;
      imm_out    <= '0;
      illegal    <= 1'b0;
    end else if (accept) begin
      ctrl_valid <= 1'b1;
      alusrc     <= dec_alusrc;
      regwrite   <= dec_regwrite;
      regsel     <= dec_regsel;
      op         <= dec_op;
      gpio_we    <= dec_gpio_we;
      rd_out     <= rd_f;
      rs1_out    <= rs1_f;
      rs2_out    <= rs2_f;
      imm_out    <= dec_imm;
      illegal    <= dec_illegal;
    end else begin
      // Bubble: strobes drop, descriptive fields keep their last values
      ctrl_valid <= 1'b0;
      regwrite   <= 1'b0;
      gpio_we    <= 1'b0;
      illegal    <= 1'b0;
    end
  end

`ifdef ILLEGAL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_cnt <= 16'd0;
    end else if (accept && dec_illegal && illegal_cnt != 16'hFFFF) begin
      illegal_cnt <= illegal_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_controlunit_pipe.sv
// Bench for controlunit_pipe: directed scenarios plus randomized instruction mix,
// checked against an instruction-level model (encoder-derived expectations, writeback history).
module tb_controlunit_pipe;
  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  localparam int K_R = 0, K_I = 1, K_LUI = 2, K_OUT = 3, K_IN = 4,
                 K_CSRBAD = 5, K_BADOP = 6, K_BADF7 = 7;

  logic            clk = 1'b0;
  logic            rst;
  logic            instr_valid;
  logic [31:0]     instr;
  logic            instr_ready, ctrl_valid, alusrc, regwrite, gpio_we, illegal;
  logic [1:0]      regsel;
  logic [3:0]      op;
  logic [4:0]      rd_out, rs1_out, rs2_out;
  logic [XLEN-1:0] imm_out;
`ifdef ILLEGAL_CNT_EN
  logic [15:0]     illegal_cnt;
`endif

  always #5 clk = ~clk;

  controlunit_pipe #(.XLEN(XLEN), .HAZARD_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .ctrl_valid(ctrl_valid), .alusrc(alusrc),
    .regwrite(regwrite), .regsel(regsel), .op(op), .gpio_we(gpio_we),
    .rd_out(rd_out), .rs1_out(rs1_out), .rs2_out(rs2_out),
    .imm_out(imm_out), .illegal(illegal)
`ifdef ILLEGAL_CNT_EN
    , .illegal_cnt(illegal_cnt)
`endif
  );

  typedef struct packed {
    logic [31:0] ins;
    logic        alusrc, regwrite, gpio_we, illegal;
    logic [1:0]  regsel;
    logic [3:0]  op;
    logic [31:0] imm;
    logic [4:0]  rd, rs1, rs2;
    logic        use1, use2, chk_alusrc, chk_regsel, chk_op, chk_imm;
  } txn_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  txn_t last;
  logic exp_cv;
  logic [4:0] hist [DEPTH];
  int   exp_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Build an instruction from its assembly-level description and state what it must decode to
  function automatic txn_t make_txn(input int kind, input int sub, input logic [4:0] rd,
                                    input logic [4:0] rs1, input logic [4:0] rs2,
                                    input logic [31:0] rnd);
    txn_t t;
    logic [2:0]  f3;
    logic        alt;
    logic [11:0] c;
    t = '0;
    t.regsel = 2'b01;
    t.op     = 4'd3;
    case (sub)
      0: begin f3 = 3'b111; alt = 1'b0; end
      1: begin f3 = 3'b110; alt = 1'b0; end
      2: begin f3 = 3'b100; alt = 1'b0; end
      4: begin f3 = 3'b000; alt = 1'b1; end
      5: begin f3 = 3'b001; alt = 1'b0; end
      6: begin f3 = 3'b101; alt = 1'b0; end
      7: begin f3 = 3'b101; alt = 1'b1; end
      8: begin f3 = 3'b010; alt = 1'b0; end
      9: begin f3 = 3'b011; alt = 1'b0; end
      default: begin f3 = 3'b000; alt = 1'b0; end
    endcase
    case (kind)
      K_R: begin
        t.ins = {alt ? 7'b0100000 : 7'b0, rs2, rs1, f3, rd, 7'b0110011};
        t.op = (sub > 9) ? 4'd3 : 4'(sub);
        t.regwrite = 1'b1; t.use1 = 1'b1; t.use2 = 1'b1;
        t.chk_alusrc = 1'b1; t.chk_regsel = 1'b1; t.chk_op = 1'b1; t.chk_imm = 1'b1;
      end
      K_I: begin
        if (sub == 5 || sub == 6 || sub == 7) begin
          t.ins = {alt ? 7'b0100000 : 7'b0, rnd[4:0], rs1, f3, rd, 7'b0010011};
          t.imm = {27'b0, rnd[4:0]};
          t.op  = 4'(sub);
        end else begin
          t.ins = {rnd[11:0], rs1, f3, rd, 7'b0010011};
          t.imm = {{20{rnd[11]}}, rnd[11:0]};
          t.op  = (sub == 4 || sub > 9) ? 4'd3 : 4'(sub);
        end
        t.alusrc = 1'b1; t.regwrite = 1'b1; t.use1 = 1'b1;
        t.chk_alusrc = 1'b1; t.chk_regsel = 1'b1; t.chk_op = 1'b1; t.chk_imm = 1'b1;
      end
      K_LUI: begin
        t.ins = {rnd[31:12], rd, 7'b0110111};
        t.imm = {rnd[31:12], 12'b0};
        t.regsel = 2'b10; t.regwrite = 1'b1;
        t.chk_regsel = 1'b1; t.chk_imm = 1'b1;
      end
      K_OUT: begin
        t.ins = {12'hF02, rs1, 3'b001, rd, 7'b1110011};
        t.gpio_we = 1'b1; t.use1 = 1'b1;
      end
      K_IN: begin
        t.ins = {12'hF00, rs1, 3'b001, rd, 7'b1110011};
        t.regwrite = 1'b1; t.regsel = 2'b00; t.chk_regsel = 1'b1;
      end
      default: begin
        c = rnd[11:0];
        if (c == 12'hF00 || c == 12'hF02) c = c ^ 12'h010;
        if (kind == K_CSRBAD)      t.ins = {c, rs1, 3'b001, rd, 7'b1110011};
        else if (kind == K_BADF7)  t.ins = (sub[0]) ? {7'b0100000, rnd[4:0], rs1, 3'b001, rd, 7'b0010011}
                                                    : {7'b0000001, rs2, rs1, rnd[14:12], rd, 7'b0110011};
        else if (sub % 3 == 0)     t.ins = 32'hFFFFFFFF;
        else if (sub % 3 == 1)     t.ins = {rnd[31:7], 7'b0000011};
        else                       t.ins = {rnd[31:15], 3'b000, rd, 7'b1110011};
        t.illegal = 1'b1;
        t.chk_alusrc = 1'b1; t.chk_op = 1'b1;
      end
    endcase
    t.rd  = t.ins[11:7];
    t.rs1 = t.ins[19:15];
    t.rs2 = t.ins[24:20];
    if (t.rd == 5'd0) t.regwrite = 1'b0;
    return t;
  endfunction

  function automatic logic model_ready(input txn_t t);
    logic r = 1'b1;
    for (int i = 0; i < DEPTH; i++)
      if (hist[i] != 5'd0 && ((t.use1 && t.rs1 == hist[i]) || (t.use2 && t.rs2 == hist[i])))
        r = 1'b0;
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) hist[i] = 5'd0;
    last = '0;
    last.chk_alusrc = 1'b1; last.chk_regsel = 1'b1; last.chk_op = 1'b1; last.chk_imm = 1'b1;
    exp_cv  = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic check_outputs();
    check("ctrl_valid", ctrl_valid, exp_cv);
    check("regwrite", regwrite, exp_cv & last.regwrite);
    check("gpio_we", gpio_we, exp_cv & last.gpio_we);
    check("illegal", illegal, exp_cv & last.illegal);
    check("rd_out", rd_out, last.rd);
    check("rs1_out", rs1_out, last.rs1);
    check("rs2_out", rs2_out, last.rs2);
    if (last.chk_alusrc) check("alusrc", alusrc, last.alusrc);
    if (last.chk_regsel) check("regsel", regsel, last.regsel);
    if (last.chk_op)     check("op", op, last.op);
    if (last.chk_imm)    check("imm_out", imm_out, last.imm);
`ifdef ILLEGAL_CNT_EN
    check("illegal_cnt", illegal_cnt, exp_cnt);
`endif
  endtask

  // One clock: present, check ready, advance model, check registered outputs
  task automatic cycle(input logic v, input txn_t t, output logic acc);
    logic er;
    instr_valid = v;
    instr       = t.ins;
    #1;
    er = model_ready(t);
    if (v) check("instr_ready", instr_ready, er);
    acc = v && er;
    for (int i = DEPTH - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = (acc && t.regwrite) ? t.rd : 5'd0;
    if (acc) begin
      last   = t;
      exp_cv = 1'b1;
      if (t.illegal && exp_cnt < 65535) exp_cnt++;
    end else begin
      exp_cv = 1'b0;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic issue(input txn_t t, output int stalls);
    logic acc = 1'b0;
    stalls = 0;
    while (!acc && stalls < 8) begin
      cycle(1'b1, t, acc);
      if (!acc) stalls++;
    end
    check("accept_timeout", acc, 1'b1);
    $display("txn instr=%08h stalls=%0d ctrl_valid=%0b op=%0d regwrite=%0b illegal=%0b",
             t.ins, stalls, ctrl_valid, op, regwrite, illegal);
  endtask

  initial begin
    txn_t t_addi, t_add, t;
    int   st;
    logic acc;
    rst = 1'b1; instr_valid = 1'b0; instr = 32'h0;
    model_clear();
    #2;
    check_outputs();
    check("reset_ready", instr_ready, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // addi x1,x0,5 then dependent add x2,x1,x1
    t_addi = make_txn(K_I, 3, 5'd1, 5'd0, 5'd0, 32'd5);
    t_add  = make_txn(K_R, 3, 5'd2, 5'd1, 5'd1, 32'd0);
    issue(t_addi, st);
    check("t1_instr", instr, 32'h00500093);
    check("t1_imm", imm_out, 32'd5);
    issue(t_add, st);
    check("raw_stalls", st, DEPTH);
    check("raw_alusrc", alusrc, 1'b0);

    // lui x3,0xFFFFF then csrrw x0,0xF02,x3
    issue(make_txn(K_LUI, 0, 5'd3, 5'd0, 5'd0, 32'hFFFFF000), st);
    check("lui_imm", imm_out, 32'hFFFFF000);
    check("lui_regsel", regsel, 2'b10);
    issue(make_txn(K_OUT, 0, 5'd0, 5'd3, 5'd0, 32'd0), st);
    check("csr_out_stalls", st, DEPTH);
    check("csr_out_we", gpio_we, 1'b1);

    // csrrw x4,0xF00,x0 ; addi x0,x0,1 ; add x6,x0,x0
    issue(make_txn(K_IN, 0, 5'd4, 5'd0, 5'd0, 32'd0), st);
    check("csr_in_regsel", regsel, 2'b00);
    issue(make_txn(K_I, 3, 5'd0, 5'd0, 5'd0, 32'd1), st);
    check("x0_regwrite", regwrite, 1'b0);
    issue(make_txn(K_R, 3, 5'd6, 5'd0, 5'd0, 32'd0), st);
    check("x0_stalls", st, 0);

    // reset in the middle of a RAW stall
    issue(t_addi, st);
    cycle(1'b1, t_add, acc);
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    check_outputs();
    check("rst_ready", instr_ready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    issue(t_add, st);
    check("post_rst_stalls", st, 0);

    // illegal encodings never stall and consume one slot
    for (int i = 0; i < 3; i++) begin
      issue(make_txn(K_BADOP, 0, 5'd0, 5'd0, 5'd0, 32'd0), st);
      check("illegal_stalls", st, 0);
    end
    check("illegal_flag", illegal, 1'b1);

    // randomized mix with narrow register range for frequent hazards
    for (int n = 0; n < 250; n++) begin
      t = make_txn($urandom_range(0, 7), $urandom_range(0, 9), 5'($urandom_range(0, 5)),
                   5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)), $urandom);
      if ($urandom_range(0, 4) == 0) cycle(1'b0, t, acc);
      else                           issue(t, st);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
